eae_sequencer: RTL and testbench
================================

Name: eae_sequencer

Overview:
- Upstream control stage for the EAE arithmetic block.
- Accepts one decoded EAE operation from the CPU control unit, plus AC/MQ/link and the operand word.
- For MUY/DVI: pulses the EAE start line, waits for finish, then captures the product or quotient/remainder.
- Executes the shift-class operations (SHL, ASR, LSR, NMI) itself, one bit per cycle, and returns AC/MQ/link/SC to the CPU with a done pulse.

Parameters:
- TIMEOUT, 64, maximum cycles to wait for eae_fin before aborting with err.
- WIDTH, 12, PDP-8 word width. AC:MQ forms 2*WIDTH bits.

Ports:
- clock  in  1  system clock, rising-edge.
- resetN  in  1  asynchronous, active-low reset.
- op_valid  in  1  CPU presents an operation.
- op_ready  out  1  high only in IDLE. Transfer occurs when op_valid & op_ready at a rising edge.
- op_code  in  eae_op_t  NOP/MUY/DVI/SHL/ASR/LSR/NMI.
- ac_in, mq_in  in  12  operand registers.
- link_in  in  1  link register.
- operand  in  12  memory word: multiplicand/divisor, or shift count in bits [4:0].
- eae_start  out  1  one-cycle start pulse to the EAE block.
- eae_fin  in  1  EAE multiply finished.
- fin_div  in  1  EAE divide finished.
- ac_mul, mq_mul, ac_dvi, mq_dvi  in  12  EAE result registers. Valid one cycle after the corresponding finish.
- link_dvi  in  1  divide overflow.
- ac_out, mq_out  out  12  result registers.
- link_out  out  1  result link.
- sc_out  out  5  step counter.
- done  out  1  one-cycle completion pulse. Outputs are valid from done until the next accept.
- err  out  1  set with done on timeout. Cleared at the next accept.

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE.
  - eae_start, done, err, link_out = 0.
  - ac_out, mq_out, sc_out = 0.
  - An operation in flight is abandoned; no done is issued.
- States: IDLE, START, WAIT_FIN, CAPTURE, SHIFT, DONE.
- IDLE, on accept:
  - latch ac_in, mq_in, link_in, operand and op into working registers; clear err.
  - MUY/DVI -> START.
  - SHL/ASR/LSR: cnt = operand[4:0]+1 (range 1..32) -> SHIFT.
  - NMI: sc = 0 -> SHIFT.
  - NOP or unknown code -> DONE, with registers passed through unchanged.
- START:
  - eae_start=1 for exactly this cycle; clear the timeout counter -> WAIT_FIN.
- WAIT_FIN:
  - Watch eae_fin (MUY) or fin_div (DVI).
  - When seen high -> CAPTURE.
  - A finish for the other op is ignored.
  - Timeout counter reaching TIMEOUT -> DONE with err=1 and working registers unchanged.
- CAPTURE (EAE results settle one cycle after finish):
  - MUY: AC=ac_mul, MQ=mq_mul, link=0.
  - DVI: AC=ac_dvi (remainder), MQ=mq_dvi (quotient), link=link_dvi.
  - -> DONE.
- SHIFT, one bit of 24-bit {AC,MQ} per cycle:
  - SHL: link <= AC[11]; shift left; zero fill.
  - ASR: link <= AC[11] (sign); shift right; sign fill.
  - LSR: link <= 0; shift right; zero fill.
  - SHL/ASR/LSR: cnt decrements; at cnt==1 -> DONE. sc=0 at completion.
  - Counts above 24 continue shifting, giving all-zero (SHL/LSR) or all-sign (ASR) result.
- NMI:
  - Test before each shift: if {AC,MQ}==0 or AC[11]!=AC[10] -> DONE. Otherwise shift left (link<=AC[11], zero fill) and sc++.
  - Maximum 22 shifts.
  - sc saturates at 31 (unreachable in practice).
- DONE:
  - drive outputs from working registers; done=1 for one cycle -> IDLE.
- Latency, counted from the accepting edge to the edge where done goes high:
  - SHL/ASR/LSR: N+1, where N = shift count.
  - NMI: shifts+2.
  - NOP: 1.
  - MUY/DVI: 3 + EAE latency.
- op_valid is ignored outside IDLE. No queueing; the CPU must hold op_valid until op_ready.

Decomposition:
- CPU_Definitions.pkg holds:
  - eae_op_t enum.
  - eae_seq_state_t enum.
  - WORD_W=12 constant.
- One natural sub-module, eae_shift_step: combinational single-step shifter. Inputs {AC,MQ}, link and mode; outputs next {AC,MQ}, link and the NMI stop flag.

Test Plan:
- MUY: AC=0x000, MQ=0x005, operand=0x007; stub asserts eae_fin 4 cycles after eae_start, with ac_mul=0x000, mq_mul=0x023 the following cycle -> single eae_start pulse; done with ac_out=0x000, mq_out=0x023, link_out=0.
- DVI: AC=0x000, MQ=0x064, operand=0x007; stub returns mq_dvi=0x00E, ac_dvi=0x002, link_dvi=0 -> mq_out=0x00E, ac_out=0x002, link_out=0. A second DVI whose stub returns link_dvi=1 -> link_out=1.
- SHL: AC=0x001, MQ=0x800, operand=0x002 -> after 3 shifts: ac_out=0x00C, mq_out=0x000, link_out=0; done exactly 4 edges after accept. ASR: AC=0x800, MQ=0x000, operand=0x000 -> ac_out=0xC00, link_out=1.
- NMI: AC=0x000, MQ=0x001 -> ac_out=0x400, mq_out=0x000, sc_out=22. NMI with AC=MQ=0 -> sc_out=0, done 2 edges after accept.
- Timeout: TIMEOUT=16, MUY with stub never asserting eae_fin -> done with err=1 and ac_out/mq_out equal to inputs. The next accepted NOP clears err.
- Reset mid-op: assert resetN=0 during the 10th SHIFT cycle of SHL operand=0x01F -> immediate IDLE, all outputs 0, no done; op_ready=1 after release.

Source files
------------

// File: rtl/eae_sequencer_pkg.sv
// Shared types for the EAE control sequencer: operation codes, FSM states
// and the PDP-8 word width.
package eae_sequencer_pkg;

  localparam int WORD_W = 12;

  // Code 3'd7 is deliberately left unassigned; it is treated like NOP.
  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_MUY = 3'd1,
    OP_DVI = 3'd2,
    OP_SHL = 3'd3,
    OP_ASR = 3'd4,
    OP_LSR = 3'd5,
    OP_NMI = 3'd6
  } eae_op_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_FIN = 3'd2,
    S_CAPTURE  = 3'd3,
    S_SHIFT    = 3'd4,
    S_DONE     = 3'd5
  } eae_seq_state_t;

endpackage

// File: rtl/eae_sequencer_shift_step.sv
// Single combinational step of the {AC,MQ} shifter used by the sequencer.
// Produces the next double word, the next link and the NMI stop condition.
module eae_shift_step
  import eae_sequencer_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [2*WIDTH-1:0] i_acmq,
  input  logic               i_link,
  input  eae_op_t            i_mode,
  output logic [2*WIDTH-1:0] o_acmq,
  output logic               o_link,
  output logic               o_nmi_stop
);

  localparam int AW = 2 * WIDTH;

  // One shift of {AC,MQ}; unknown modes pass the word through untouched.
  always_comb begin
    o_acmq     = i_acmq;
    o_link     = i_link;
    // Normalised once the word is zero or the two top AC bits differ.
    o_nmi_stop = (i_acmq == '0) || (i_acmq[AW-1] != i_acmq[AW-2]);
    case (i_mode)
      OP_SHL, OP_NMI: begin
        o_acmq = {i_acmq[AW-2:0], 1'b0};
        o_link = i_acmq[AW-1];
      end
      OP_ASR: begin
        o_acmq = {i_acmq[AW-1], i_acmq[AW-1:1]};
        o_link = i_acmq[AW-1];
      end
      OP_LSR: begin
        o_acmq = {1'b0, i_acmq[AW-1:1]};
        o_link = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/eae_sequencer.sv
// EAE control sequencer. Accepts one decoded EAE operation, hands MUY/DVI
// to the external EAE block (start pulse, wait for finish, capture) and
// runs the shift-class operations itself one bit per cycle.
// Handshake: an operation transfers on a rising edge where op_valid and
// op_ready are both high; op_ready is high only in IDLE, op_valid is
// ignored elsewhere, and results are held from the done pulse until the
// next transfer.
module eae_sequencer
  import eae_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int WIDTH   = WORD_W
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             op_valid,
  output logic             op_ready,
  input  eae_op_t          op_code,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] mq_in,
  input  logic             link_in,
  input  logic [WIDTH-1:0] operand,
  output logic             eae_start,
  input  logic             eae_fin,
  input  logic             fin_div,
  input  logic [WIDTH-1:0] ac_mul,
  input  logic [WIDTH-1:0] mq_mul,
  input  logic [WIDTH-1:0] ac_dvi,
  input  logic [WIDTH-1:0] mq_dvi,
  input  logic             link_dvi,
  output logic [WIDTH-1:0] ac_out,
  output logic [WIDTH-1:0] mq_out,
  output logic             link_out,
  output logic [4:0]       sc_out,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  localparam int AW = 2 * WIDTH;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  eae_seq_state_t   r_state;
  eae_op_t          r_op;
  logic [AW-1:0]    r_acmq;
  logic             r_link;
  logic [5:0]       r_cnt;
  logic [4:0]       r_sc;
  logic [TW-1:0]    r_tmo;
  logic             r_timed_out;
  logic             r_start;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_ac_out;
  logic [WIDTH-1:0] r_mq_out;
  logic             r_link_out;
  logic [4:0]       r_sc_out;

  logic [AW-1:0]    w_acmq;
  logic             w_link;
  logic             w_nmi_stop;
  logic             w_fin_seen;
  logic             w_unused_operand;

  // Only the low five operand bits are a shift count; the rest belong to
  // the EAE block.
  assign w_unused_operand = ^operand[WIDTH-1:5];

  eae_shift_step #(.WIDTH(WIDTH)) u_step (
    .i_acmq     (r_acmq),
    .i_link     (r_link),
    .i_mode     (r_op),
    .o_acmq     (w_acmq),
    .o_link     (w_link),
    .o_nmi_stop (w_nmi_stop)
  );

  // A finish for the operation not in progress is ignored.
  assign w_fin_seen = ((r_op == OP_MUY) && eae_fin) || ((r_op == OP_DVI) && fin_div);

  assign op_ready  = (r_state == S_IDLE);
  assign eae_start = r_start;
  assign done      = r_done;
  assign err       = r_err;
  assign ac_out    = r_ac_out;
  assign mq_out    = r_mq_out;
  assign link_out  = r_link_out;
  assign sc_out    = r_sc_out;
  assign dbg_state = r_state;

  // Sequencer FSM with working registers and registered outputs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOP;
      r_acmq      <= '0;
      r_link      <= 1'b0;
      r_cnt       <= '0;
      r_sc        <= '0;
      r_tmo       <= '0;
      r_timed_out <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ac_out    <= '0;
      r_mq_out    <= '0;
      r_link_out  <= 1'b0;
      r_sc_out    <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_op        <= op_code;
            r_acmq      <= {ac_in, mq_in};
            r_link      <= link_in;
            r_cnt       <= {1'b0, operand[4:0]} + 6'd1;
            r_sc        <= '0;
            r_timed_out <= 1'b0;
            r_err       <= 1'b0;
            case (op_code)
              OP_MUY, OP_DVI: begin
                r_start <= 1'b1;
                r_state <= S_START;
              end
              OP_SHL, OP_ASR, OP_LSR, OP_NMI: r_state <= S_SHIFT;
              default:                        r_state <= S_DONE;
            endcase
          end
        end
        S_START: begin
          r_tmo   <= '0;
          r_state <= S_WAIT_FIN;
        end
        S_WAIT_FIN: begin
          if (w_fin_seen) begin
            r_state <= S_CAPTURE;
          end else if (r_tmo == TMO_LAST) begin
            r_timed_out <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_CAPTURE: begin
          if (r_op == OP_MUY) begin
            r_acmq <= {ac_mul, mq_mul};
            r_link <= 1'b0;
          end else begin
            r_acmq <= {ac_dvi, mq_dvi};
            r_link <= link_dvi;
          end
          r_state <= S_DONE;
        end
        S_SHIFT: begin
          if (r_op == OP_NMI) begin
            if (w_nmi_stop) begin
              r_state <= S_DONE;
            end else begin
              r_acmq <= w_acmq;
              r_link <= w_link;
              if (r_sc != 5'd31) r_sc <= r_sc + 5'd1;
            end
          end else begin
            r_acmq <= w_acmq;
            r_link <= w_link;
            r_cnt  <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ac_out   <= r_acmq[AW-1:WIDTH];
          r_mq_out   <= r_acmq[WIDTH-1:0];
          r_link_out <= r_link;
          r_sc_out   <= r_sc;
          r_err      <= r_timed_out;
          r_done     <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eae_sequencer.sv
// Directed plus randomized bench for eae_sequencer, with an EAE stub and a
// reference model computed from arithmetic on the 24-bit {AC,MQ} word.
module tb_eae_sequencer;
  import eae_sequencer_pkg::*;

  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        resetN;
  logic        op_valid;
  logic        op_ready;
  eae_op_t     op_code;
  logic [11:0] ac_in, mq_in, operand;
  logic        link_in;
  logic        eae_start, eae_fin, fin_div;
  logic [11:0] ac_mul, mq_mul, ac_dvi, mq_dvi;
  logic        link_dvi;
  logic [11:0] ac_out, mq_out;
  logic        link_out;
  logic [4:0]  sc_out;
  logic        done, err;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  eae_sequencer #(.TIMEOUT(TMO), .WIDTH(12)) dut (
    .clock(clock), .resetN(resetN), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .ac_in(ac_in), .mq_in(mq_in), .link_in(link_in),
    .operand(operand), .eae_start(eae_start), .eae_fin(eae_fin), .fin_div(fin_div),
    .ac_mul(ac_mul), .mq_mul(mq_mul), .ac_dvi(ac_dvi), .mq_dvi(mq_dvi),
    .link_dvi(link_dvi), .ac_out(ac_out), .mq_out(mq_out), .link_out(link_out),
    .sc_out(sc_out), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and plays the EAE block. Returns edges from the
  // accepting edge to done, and the number of eae_start cycles seen.
  task automatic do_op(input eae_op_t op, input logic [11:0] a, input logic [11:0] m,
                       input logic l, input logic [11:0] opd, input int fin_lat,
                       input bit fin_never, input bit wrong_fin,
                       input logic [11:0] ra, input logic [11:0] rm, input logic rl,
                       output int lat, output int starts);
    int s;
    bit seen;
    check("op_ready_before_accept", op_ready, 1);
    op_valid = 1'b1; op_code = op; ac_in = a; mq_in = m; link_in = l; operand = opd;
    ac_mul = 12'($urandom); mq_mul = 12'($urandom);
    ac_dvi = 12'($urandom); mq_dvi = 12'($urandom); link_dvi = 1'($urandom);
    eae_fin = 1'b0; fin_div = 1'b0;
    @(posedge clock);
    @(negedge clock);
    op_valid = 1'b0;
    ac_in = 12'($urandom); mq_in = 12'($urandom); link_in = 1'($urandom);
    operand = 12'($urandom);
    lat = 0; starts = 0; s = -1; seen = 1'b0;
    if (eae_start) begin starts++; s = 0; end
    while (!seen && lat < 200) begin
      eae_fin = 1'b0; fin_div = 1'b0;
      if (s >= 0 && !fin_never) begin
        if (lat == s + fin_lat) begin
          if (op == OP_MUY) eae_fin = 1'b1; else fin_div = 1'b1;
        end
        if (lat == s + fin_lat + 1) begin
          if (op == OP_MUY) begin ac_mul = ra; mq_mul = rm; end
          else begin ac_dvi = ra; mq_dvi = rm; link_dvi = rl; end
        end
      end
      if (wrong_fin && s >= 0 && lat == s + 1) begin
        if (op == OP_MUY) fin_div = 1'b1; else eae_fin = 1'b1;
      end
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (eae_start) begin starts++; if (s < 0) s = lat; end
      if (done) seen = 1'b1;
    end
    eae_fin = 1'b0; fin_div = 1'b0;
    check("done_within_budget", seen, 1);
  endtask

  // Runs one operation and compares against the reference model.
  task automatic run_check(input string tag, input eae_op_t op, input logic [11:0] a,
                           input logic [11:0] m, input logic l, input logic [11:0] opd,
                           input int fin_lat, input bit fin_never, input bit wrong_fin);
    logic [23:0] v, t, ev, p;
    logic [11:0] ra, rm;
    logic        rl, el, eerr;
    int          n, k, esc, elat, est, lat, starts;
    v = {a, m}; ev = v; el = l; esc = 0; eerr = 1'b0; est = 0; k = 0;
    n = int'(opd[4:0]) + 1;
    // What the EAE block computes.
    p = 24'(m) * 24'(opd);
    ra = p[23:12]; rm = p[11:0]; rl = 1'b0;
    if (op == OP_DVI) begin
      if (opd == 12'd0 || a >= opd) begin
        ra = a; rm = m; rl = 1'b1;
      end else begin
        t = v % 24'(opd); ra = t[11:0];
        t = v / 24'(opd); rm = t[11:0]; rl = 1'b0;
      end
    end
    case (op)
      OP_MUY, OP_DVI: begin
        est = 1;
        if (fin_never) begin
          eerr = 1'b1; elat = -1;
        end else begin
          ev = {ra, rm}; el = (op == OP_DVI) ? rl : 1'b0; elat = fin_lat + 3;
        end
      end
      OP_SHL: begin
        t = v << (n - 1); el = t[23]; ev = t << 1; elat = n + 1;
      end
      OP_ASR: begin
        ev = 24'($signed(v) >>> n); el = v[23]; elat = n + 1;
      end
      OP_LSR: begin
        ev = v >> n; el = 1'b0; elat = n + 1;
      end
      OP_NMI: begin
        while (ev != 24'd0 && ev[23] == ev[22]) begin
          el = ev[23]; ev = ev << 1; k++;
        end
        esc = k; elat = k + 2;
      end
      default: elat = 1;
    endcase
    do_op(op, a, m, l, opd, fin_lat, fin_never, wrong_fin, ra, rm, rl, lat, starts);
    check({tag, "_ac"}, ac_out, ev[23:12]);
    check({tag, "_mq"}, mq_out, ev[11:0]);
    check({tag, "_link"}, link_out, el);
    check({tag, "_sc"}, sc_out, esc);
    check({tag, "_err"}, err, eerr);
    check({tag, "_starts"}, starts, est);
    if (elat >= 0) check({tag, "_latency"}, lat, elat);
    @(negedge clock);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold_ac"}, ac_out, ev[23:12]);
  endtask

  initial begin
    int cnt;
    eae_op_t rop;
    logic [2:0] rcode;
    int fl;
    bit wf;
    resetN = 1'b0; op_valid = 1'b0; op_code = OP_NOP;
    ac_in = '0; mq_in = '0; link_in = 1'b0; operand = '0;
    eae_fin = 1'b0; fin_div = 1'b0;
    ac_mul = '0; mq_mul = '0; ac_dvi = '0; mq_dvi = '0; link_dvi = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_ac", ac_out, 0);
    check("reset_mq", mq_out, 0);
    check("reset_link", link_out, 0);
    check("reset_sc", sc_out, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_start", eae_start, 0);
    check("reset_ready", op_ready, 1);
    check("reset_state", dbg_state, S_IDLE);
    resetN = 1'b1;
    @(negedge clock);

    // Directed cases
    run_check("muy",      OP_MUY, 12'h000, 12'h005, 1'b1, 12'h007, 4, 1'b0, 1'b0);
    run_check("muy_xfin", OP_MUY, 12'h000, 12'h0AB, 1'b0, 12'h013, 5, 1'b0, 1'b1);
    run_check("dvi",      OP_DVI, 12'h000, 12'h064, 1'b1, 12'h007, 3, 1'b0, 1'b1);
    run_check("dvi_ovf",  OP_DVI, 12'h010, 12'h000, 1'b0, 12'h007, 2, 1'b0, 1'b0);
    run_check("shl",      OP_SHL, 12'h001, 12'h800, 1'b1, 12'h002, 0, 1'b0, 1'b0);
    run_check("asr",      OP_ASR, 12'h800, 12'h000, 1'b0, 12'h000, 0, 1'b0, 1'b0);
    run_check("lsr_32",   OP_LSR, 12'hFFF, 12'hFFF, 1'b1, 12'h01F, 0, 1'b0, 1'b0);
    run_check("asr_32",   OP_ASR, 12'h9A5, 12'h123, 1'b0, 12'h01F, 0, 1'b0, 1'b0);
    run_check("shl_25",   OP_SHL, 12'hFFF, 12'hFFF, 1'b0, 12'h018, 0, 1'b0, 1'b0);
    run_check("nmi",      OP_NMI, 12'h000, 12'h001, 1'b1, 12'h000, 0, 1'b0, 1'b0);
    run_check("nmi_zero", OP_NMI, 12'h000, 12'h000, 1'b1, 12'h000, 0, 1'b0, 1'b0);
    run_check("nmi_neg",  OP_NMI, 12'hE00, 12'h055, 1'b0, 12'h000, 0, 1'b0, 1'b0);
    run_check("nop",      OP_NOP, 12'h5A5, 12'h3C3, 1'b1, 12'h0FF, 0, 1'b0, 1'b0);
    run_check("unknown",  eae_op_t'(3'd7), 12'h123, 12'h456, 1'b0, 12'h001, 0, 1'b0, 1'b0);

    // Timeout, then a NOP clears err
    run_check("timeout",  OP_MUY, 12'hABC, 12'hDEF, 1'b1, 12'h007, 0, 1'b1, 1'b0);
    run_check("nop_clr",  OP_NOP, 12'h001, 12'h002, 1'b0, 12'h000, 0, 1'b0, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rcode = 3'($urandom_range(0, 7));
      rop = eae_op_t'(rcode);
      fl = $urandom_range(1, 6);
      wf = (fl >= 2) && ($urandom_range(0, 1) == 1);
      run_check("rand", rop, 12'($urandom), 12'($urandom), 1'($urandom), 12'($urandom),
                fl, 1'b0, wf);
    end

    // Leave non-zero outputs, then reset during the 10th SHIFT cycle.
    run_check("pre_reset", OP_NMI, 12'h000, 12'h003, 1'b1, 12'h000, 0, 1'b0, 1'b0);
    op_valid = 1'b1; op_code = OP_SHL; ac_in = 12'hABC; mq_in = 12'h123;
    link_in = 1'b1; operand = 12'h01F;
    @(posedge clock);
    @(negedge clock);
    op_valid = 1'b0;
    cnt = 0;
    repeat (9) begin
      @(negedge clock);
      if (done) cnt++;
    end
    check("mid_op_no_done", cnt, 0);
    resetN = 1'b0;
    #1;
    check("mid_reset_ready", op_ready, 1);
    check("mid_reset_ac", ac_out, 0);
    check("mid_reset_mq", mq_out, 0);
    check("mid_reset_link", link_out, 0);
    check("mid_reset_sc", sc_out, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_err", err, 0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) cnt++;
    end
    check("post_reset_no_done", cnt, 0);
    check("post_reset_ready", op_ready, 1);
    run_check("post_reset_nop", OP_NOP, 12'h777, 12'h111, 1'b1, 12'h000, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
